// File: rtl/period_meter_pkg.sv
// -----------------------------------------------------------------------------
// period_meter_pkg
// Shared definitions for the period meter: the measurement FSM state type,
// default parameter values, and a small width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int CNT_W_DEF      = 21;
  localparam int MIN_HALF_DEF   = 45000;
  localparam int MAX_HALF_DEF   = 55000;
  localparam int LOCK_COUNT_DEF = 4;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/period_meter_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings the asynchronous sig_in into the clk_in domain through two flops,
// keeps the previous synchronized value, and emits a registered one-cycle
// pulse on either edge. The output register fixes the latency from the first
// sample of a sig_in change to the pulse at a constant number of cycles.
// Ports:
//   clk_in   - only clock
//   rst      - synchronous, active-high reset
//   sig_in   - asynchronous input
//   edge_det - one-cycle pulse per rising or falling edge of sig_in
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk_in,
  input  logic rst,
  input  logic sig_in,
  output logic edge_det
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;
  logic edge_q,  edge_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_d  = sync2_q ^ prev_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
    end
  end

  assign edge_det = edge_q;

endmodule

// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
// Measures the half-period of a slow asynchronous clock (sig_in) in clk_in
// cycles, flags lock when LOCK_COUNT consecutive measurements fall within
// [MIN_HALF, MAX_HALF], and flags timeout when no edge arrives before the
// counter saturates.
// Optional feature: define PERIOD_METER_STATS_EN to add min_half/max_half,
// the extremes of all valid measurements since reset.
// Ports:
//   clk_in      - only clock
//   rst         - synchronous, active-high reset
//   sig_in      - asynchronous signal to measure
//   half_period - last measured half-period (CNT_W bits)
//   valid       - one-cycle pulse when half_period updates
//   locked      - lock criterion currently met
//   timeout     - sig_in stuck long enough to saturate the counter
//   min_half    - (PERIOD_METER_STATS_EN) smallest measurement since reset
//   max_half    - (PERIOD_METER_STATS_EN) largest measurement since reset
// -----------------------------------------------------------------------------
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MIN_HALF   = MIN_HALF_DEF,
  parameter int MAX_HALF   = MAX_HALF_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             valid,
  output logic             locked,
  output logic             timeout
`ifdef PERIOD_METER_STATS_EN
  ,
  output logic [CNT_W-1:0] min_half,
  output logic [CNT_W-1:0] max_half
`endif
);

  localparam int               CONS_W  = cnt_bits(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_L   = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_HALF);
  localparam logic [CONS_W-1:0] LOCK_L = CONS_W'(LOCK_COUNT);

  logic edge_det;

  edge_sync u_edge_sync (
    .clk_in   (clk_in),
    .rst      (rst),
    .sig_in   (sig_in),
    .edge_det (edge_det)
  );

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [CNT_W-1:0]  hp_q,      hp_d;
  logic              valid_q,   valid_d;
  logic              locked_q,  locked_d;
  logic              timeout_q, timeout_d;
  logic [CONS_W-1:0] consec_q,  consec_d;
`ifdef PERIOD_METER_STATS_EN
  logic [CNT_W-1:0]  min_q,     min_d;
  logic [CNT_W-1:0]  max_q,     max_d;
`endif

  logic in_range;
  assign in_range = (count_q >= MIN_L) && (count_q <= MAX_L);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hp_d      = hp_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    consec_d  = consec_q;
`ifdef PERIOD_METER_STATS_EN
    min_d     = min_q;
    max_d     = max_q;
`endif
    case (state_q)
      IDLE: begin
        // First edge only starts a measurement; there is nothing to report.
        if (edge_det) begin
          count_d   = CNT_ONE;
          state_d   = MEASURE;
          timeout_d = 1'b0;
        end
      end
      MEASURE: begin
        // An edge wins over saturation, so a full-scale count is reported.
        if (edge_det) begin
          hp_d      = count_q;
          valid_d   = 1'b1;
          count_d   = CNT_ONE;
          timeout_d = 1'b0;
          if (in_range) begin
            consec_d = (consec_q == LOCK_L) ? consec_q : consec_q + CONS_W'(1);
          end else begin
            consec_d = '0;
          end
          locked_d = (consec_d == LOCK_L);
`ifdef PERIOD_METER_STATS_EN
          if (count_q < min_q) min_d = count_q;
          if (count_q > max_q) max_d = count_q;
`endif
        end else if (count_q == CNT_MAX) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          consec_d  = '0;
          count_d   = '0;
          state_d   = IDLE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hp_q      <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      consec_q  <= '0;
`ifdef PERIOD_METER_STATS_EN
      min_q     <= CNT_MAX;
      max_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hp_q      <= hp_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      consec_q  <= consec_d;
`ifdef PERIOD_METER_STATS_EN
      min_q     <= min_d;
      max_q     <= max_d;
`endif
    end
  end

  assign half_period = hp_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;
`ifdef PERIOD_METER_STATS_EN
  assign min_half    = min_q;
  assign max_half    = max_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
// Scaled-down check of period_meter (CNT_W=8, range 90..110, nominal 100).
// sig_in is toggled at chosen intervals; a reference model that only knows
// the toggle intervals predicts valid, half_period, locked, timeout (and the
// min/max statistics when PERIOD_METER_STATS_EN is defined).
// -----------------------------------------------------------------------------
module tb_period_meter;

  localparam int CW   = 8;
  localparam int MINH = 90;
  localparam int MAXH = 110;
  localparam int LOCK = 4;
  localparam int SAT  = (1 << CW) - 1;
  localparam int LAT  = 4;  // toggle cycle -> valid visible

  logic          clk_in = 1'b0;
  logic          rst    = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] half_period;
  logic          valid;
  logic          locked;
  logic          timeout;
`ifdef PERIOD_METER_STATS_EN
  logic [CW-1:0] min_half;
  logic [CW-1:0] max_half;
`endif

  period_meter #(
    .CNT_W      (CW),
    .MIN_HALF   (MINH),
    .MAX_HALF   (MAXH),
    .LOCK_COUNT (LOCK)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .sig_in      (sig_in),
    .half_period (half_period),
    .valid       (valid),
    .locked      (locked),
    .timeout     (timeout)
`ifdef PERIOD_METER_STATS_EN
    ,
    .min_half    (min_half),
    .max_half    (max_half)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_tog = 0;

  // Reference model state
  bit m_meas;
  int m_consec;
  bit m_locked;
  int m_min;
  int m_max;

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_meas   = 1'b0;
    m_consec = 0;
    m_locked = 1'b0;
    m_min    = SAT;
    m_max    = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_val("rst_valid", int'(valid), 0);
    check_val("rst_hp", int'(half_period), 0);
    check_val("rst_locked", int'(locked), 0);
    check_val("rst_timeout", int'(timeout), 0);
`ifdef PERIOD_METER_STATS_EN
    check_val("rst_min", int'(min_half), SAT);
    check_val("rst_max", int'(max_half), 0);
`endif
    rst = 1'b0;
    model_reset();
    $display("reset at cycle %0d", cyc);
  endtask

  // Toggle sig_in now, then hold it for n cycles while checking the outcome.
  task automatic toggle_wait(input int n_in);
    int  n;
    int  gap;
    bit  pre_to;
    bit  ev;
    bit  pre_locked;
    bit  stray;
    n   = (n_in < 5) ? 5 : n_in;
    gap = cyc - last_tog;
    // A gap longer than the counter range means the counter saturated.
    pre_to = m_meas && (gap > SAT);
    ev     = m_meas && !pre_to;
    if (pre_to) begin
      m_consec = 0;
      m_locked = 1'b0;
    end
    pre_locked = m_locked;
    if (ev) begin
      if (gap >= MINH && gap <= MAXH) m_consec = (m_consec < LOCK) ? m_consec + 1 : LOCK;
      else m_consec = 0;
      m_locked = (m_consec == LOCK);
      if (gap < m_min) m_min = gap;
      if (gap > m_max) m_max = gap;
    end
    m_meas = 1'b1;

    sig_in   = ~sig_in;
    last_tog = cyc;
    stray    = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (k == LAT - 1) begin
        check_val("timeout_pre", int'(timeout), int'(pre_to));
        check_val("locked_pre", int'(locked), int'(pre_locked));
      end
      if (k == LAT) begin
        check_val("valid", int'(valid), int'(ev));
        if (ev) check_val("half_period", int'(half_period), gap);
        check_val("locked", int'(locked), int'(m_locked));
        check_val("timeout_clr", int'(timeout), 0);
`ifdef PERIOD_METER_STATS_EN
        check_val("min_half", int'(min_half), m_min);
        check_val("max_half", int'(max_half), m_max);
`endif
      end else if (valid) begin
        stray = 1'b1;
      end
    end
    check_val("no_stray_valid", int'(stray), 0);
    $display("edge gap=%0d exp_valid=%0d hp=%0d locked=%0d timeout_pre=%0d",
             gap, ev, half_period, locked, pre_to);
  endtask

  // Reset 20 cycles into a low half-period so no spurious post-reset edge.
  task automatic reset_mid();
    bit stray;
    if (sig_in == 1'b0) toggle_wait(100);
    toggle_wait(20);
    do_reset();
    stray = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (valid) stray = 1'b1;
    end
    check_val("post_rst_quiet", int'(stray), 0);
  endtask

  initial begin
    int r;
    int n;
    model_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    repeat (3) tick();
    do_reset();
    last_tog = cyc;

    // Nominal: first edge silent, then 100s; lock on the 4th valid.
    repeat (6) toggle_wait(100);
    // Out of range high: never locks.
    repeat (5) toggle_wait(120);
    // Lock, one short half-period, relock.
    repeat (5) toggle_wait(100);
    toggle_wait(80);
    repeat (5) toggle_wait(100);
    // Range and counter boundaries.
    toggle_wait(90);
    toggle_wait(110);
    toggle_wait(89);
    toggle_wait(111);
    toggle_wait(255);
    toggle_wait(256);
    toggle_wait(300);
    repeat (3) toggle_wait(100);
    // Reset in the middle of a half-period.
    reset_mid();
    repeat (4) toggle_wait(100);
    // Statistics extremes.
    do_reset();
    toggle_wait(100);
    toggle_wait(96);
    toggle_wait(104);
    toggle_wait(100);
    toggle_wait(100);

    // Randomized intervals.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        reset_mid();
      end else begin
        if (r < 12)      n = $urandom_range(MINH - 2, MAXH + 2);
        else if (r < 18) n = $urandom_range(5, SAT - 1);
        else             n = $urandom_range(SAT - 5, SAT + 25);
        toggle_wait(n);
      end
    end
    toggle_wait(100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
